// File: rtl/stk_pkg.sv
// Shared types and constants for the stack engine writeback stage.
package stk_pkg;

  localparam int unsigned ENGS_N   = 4;
  localparam int unsigned PTR_W    = 8;
  localparam int unsigned DAT_W    = 128;
  localparam int unsigned DQ_DEPTH = 4;
  localparam int unsigned ENGID_W  = $clog2(ENGS_N);
  // Per-engine line count must be able to hold 2^PTR_W.
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef logic [ENGID_W-1:0] engid_t;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [DAT_W-1:0]   dat_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_RSVD = 2'd3
  } opcode_t;

  localparam cnt_t CNT_MAX = {1'b1, {PTR_W{1'b0}}};

endpackage

// File: rtl/stk_pipe_wrbk_if.sv
// Writeback bus: registered update from MEM plus the dealloc handshake to AL.
//   slave  : writeback stage side (consumes update, drives dealloc vld/ptr)
//   master : upstream/allocator side
interface stk_pipe_wrbk_if;
  import stk_pkg::*;

  logic    wrbk_uc_vld_r;
  engid_t  wrbk_uc_engid_r;
  logic [1:0] wrbk_uc_opcode_r;
  logic    wrbk_uc_head_vld_r;
  ptr_t    wrbk_uc_head_ptr_r;
  logic    wrbk_uc_tail_vld_r;
  ptr_t    wrbk_uc_tail_ptr_r;
  ptr_t    wrbk_pop_ptr_r;
  dat_t    wrbk_dat_r;
  logic    dealloc_vld;
  ptr_t    dealloc_ptr;
  logic    dealloc_rdy;

  modport slave (
    input  wrbk_uc_vld_r, wrbk_uc_engid_r, wrbk_uc_opcode_r,
           wrbk_uc_head_vld_r, wrbk_uc_head_ptr_r,
           wrbk_uc_tail_vld_r, wrbk_uc_tail_ptr_r,
           wrbk_pop_ptr_r, wrbk_dat_r, dealloc_rdy,
    output dealloc_vld, dealloc_ptr
  );

  modport master (
    output wrbk_uc_vld_r, wrbk_uc_engid_r, wrbk_uc_opcode_r,
           wrbk_uc_head_vld_r, wrbk_uc_head_ptr_r,
           wrbk_uc_tail_vld_r, wrbk_uc_tail_ptr_r,
           wrbk_pop_ptr_r, wrbk_dat_r, dealloc_rdy,
    input  dealloc_vld, dealloc_ptr
  );

endinterface

// File: rtl/stk_pipe_wrbk_dq.sv
// Dealloc queue: first-word fall-through FIFO of freed pointers.
//   clk, arst_n : clock, synchronous active-low reset
//   enq_i/enq_dat_i : push request and data
//   deq_rdy_i       : consumer accepts head this cycle
//   vld_o/dat_o     : head valid / head data (from queue state)
//   busy_o          : registered, occupancy >= DEPTH-2
//   ovf_o           : sticky, push dropped while full
module stk_pipe_wrbk_dq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         enq_i,
  input  logic [W-1:0] enq_dat_i,
  input  logic         deq_rdy_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  output logic         busy_o,
  output logic         ovf_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned QCW   = $clog2(DEPTH + 1);

  logic [W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [QCW-1:0] cnt_q, cnt_d;
  logic           busy_q, ovf_q;
  logic           full, empty, deq, enq_ok, drop;

  // Full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    full   = (cnt_q == QCW'(DEPTH));
    empty  = (cnt_q == '0);
    deq    = ~empty & deq_rdy_i;
    enq_ok = enq_i & (~full | deq);
    drop   = enq_i & full & ~deq;
    cnt_d  = cnt_q;
    if (enq_ok & ~deq) cnt_d = cnt_q + QCW'(1);
    else if (~enq_ok & deq) cnt_d = cnt_q - QCW'(1);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (enq_ok) begin
        mem_q[wptr_q] <= enq_dat_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (deq) rptr_q <= rptr_q + AW'(1);
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d >= QCW'(DEPTH - 2));
      ovf_q  <= ovf_q | drop;
    end
  end

  assign vld_o  = ~empty;
  assign dat_o  = mem_q[rptr_q];
  assign busy_o = busy_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/stk_pipe_wrbk.sv
// Writeback stage of the stack engine pipeline: commits per-engine context,
// issues per-engine responses, and returns freed pointers through a queue.
//   clk, arst_n      : clock, synchronous active-low reset
//   bus_if (slave)   : MEM update in, dealloc handshake out
//   o_rsp_*          : one-cycle response (one-hot engine strobe, err, data)
//   o_ctxt_*_r       : committed head/tail/empty per engine
//   o_ad_busy_r      : admission throttle
//   o_err_ovf_r      : sticky dealloc-queue overflow
module stk_pipe_wrbk
  import stk_pkg::*;
(
  input  logic                      clk,
  input  logic                      arst_n,
  stk_pipe_wrbk_if.slave            bus_if,
  output logic [ENGS_N-1:0]         o_rsp_vld,
  output logic                      o_rsp_err,
  output logic [DAT_W-1:0]          o_rsp_dat,
  output logic [ENGS_N-1:0]         o_ctxt_head_vld_r,
  output logic [ENGS_N*PTR_W-1:0]   o_ctxt_head_ptr_r,
  output logic [ENGS_N-1:0]         o_ctxt_tail_vld_r,
  output logic [ENGS_N*PTR_W-1:0]   o_ctxt_tail_ptr_r,
  output logic [ENGS_N-1:0]         o_ctxt_empty_r,
  output logic                      o_ad_busy_r,
  output logic                      o_err_ovf_r
);

  logic [ENGS_N-1:0]            head_vld_q, tail_vld_q, empty_q;
  logic [ENGS_N-1:0][PTR_W-1:0] head_ptr_q, tail_ptr_q;
  cnt_t                         cnt_q [ENGS_N];
  logic [ENGS_N-1:0]            rsp_vld_q;
  logic                         rsp_err_q;
  dat_t                         rsp_dat_q;

  opcode_t op;
  engid_t  eid;
  cnt_t    cur_cnt;
  logic    err_c, commit_c, push_c, pop_ok_c;

  // Decode: reserved opcodes, POP on empty and PUSH at saturation are errors.
  always_comb begin
    op       = opcode_t'(bus_if.wrbk_uc_opcode_r);
    eid      = bus_if.wrbk_uc_engid_r;
    cur_cnt  = cnt_q[eid];
    err_c    = 1'b0;
    push_c   = 1'b0;
    case (op)
      OP_PUSH: begin
        push_c = 1'b1;
        err_c  = (cur_cnt == CNT_MAX);
      end
      OP_POP:  err_c = (cur_cnt == '0);
      OP_RSVD: err_c = 1'b1;
      default: err_c = 1'b0;
    endcase
    commit_c = bus_if.wrbk_uc_vld_r & ~err_c & (op != OP_NOP);
    pop_ok_c = commit_c & ~push_c;
  end

  // Context commit and registered response.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      head_vld_q <= '0;
      tail_vld_q <= '0;
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      empty_q    <= '1;
      for (int i = 0; i < int'(ENGS_N); i++) cnt_q[i] <= '0;
      rsp_vld_q  <= '0;
      rsp_err_q  <= 1'b0;
      rsp_dat_q  <= '0;
    end else begin
      rsp_vld_q <= bus_if.wrbk_uc_vld_r ? (ENGS_N'(1) << eid) : '0;
      rsp_err_q <= bus_if.wrbk_uc_vld_r & err_c;
      rsp_dat_q <= pop_ok_c ? bus_if.wrbk_dat_r : '0;
      if (commit_c) begin
        head_vld_q[eid] <= bus_if.wrbk_uc_head_vld_r;
        head_ptr_q[eid] <= bus_if.wrbk_uc_head_ptr_r;
        tail_vld_q[eid] <= bus_if.wrbk_uc_tail_vld_r;
        tail_ptr_q[eid] <= bus_if.wrbk_uc_tail_ptr_r;
        cnt_q[eid]      <= push_c ? (cur_cnt + CNT_W'(1)) : (cur_cnt - CNT_W'(1));
        empty_q[eid]    <= push_c ? 1'b0 : (cur_cnt == CNT_W'(1));
      end
    end
  end

  stk_pipe_wrbk_dq #(
    .DEPTH (DQ_DEPTH),
    .W     (PTR_W)
  ) u_dq (
    .clk       (clk),
    .arst_n    (arst_n),
    .enq_i     (pop_ok_c),
    .enq_dat_i (bus_if.wrbk_pop_ptr_r),
    .deq_rdy_i (bus_if.dealloc_rdy),
    .vld_o     (bus_if.dealloc_vld),
    .dat_o     (bus_if.dealloc_ptr),
    .busy_o    (o_ad_busy_r),
    .ovf_o     (o_err_ovf_r)
  );

  assign o_rsp_vld         = rsp_vld_q;
  assign o_rsp_err         = rsp_err_q;
  assign o_rsp_dat         = rsp_dat_q;
  assign o_ctxt_head_vld_r = head_vld_q;
  assign o_ctxt_head_ptr_r = head_ptr_q;
  assign o_ctxt_tail_vld_r = tail_vld_q;
  assign o_ctxt_tail_ptr_r = tail_ptr_q;
  assign o_ctxt_empty_r    = empty_q;

endmodule

// File: tb/tb_stk_pipe_wrbk.sv
// Directed bench for the writeback stage: context commit, responses,
// dealloc queue occupancy, throttle, overflow and pointer wrap.
module tb_stk_pipe_wrbk;
  import stk_pkg::*;

  logic clk = 1'b0;
  logic arst_n;
  logic [ENGS_N-1:0]       o_rsp_vld;
  logic                    o_rsp_err;
  logic [DAT_W-1:0]        o_rsp_dat;
  logic [ENGS_N-1:0]       o_ctxt_head_vld_r;
  logic [ENGS_N*PTR_W-1:0] o_ctxt_head_ptr_r;
  logic [ENGS_N-1:0]       o_ctxt_tail_vld_r;
  logic [ENGS_N*PTR_W-1:0] o_ctxt_tail_ptr_r;
  logic [ENGS_N-1:0]       o_ctxt_empty_r;
  logic                    o_ad_busy_r;
  logic                    o_err_ovf_r;

  int tests = 0;
  int fails = 0;

  stk_pipe_wrbk_if bus ();

  stk_pipe_wrbk dut (
    .clk               (clk),
    .arst_n            (arst_n),
    .bus_if            (bus),
    .o_rsp_vld         (o_rsp_vld),
    .o_rsp_err         (o_rsp_err),
    .o_rsp_dat         (o_rsp_dat),
    .o_ctxt_head_vld_r (o_ctxt_head_vld_r),
    .o_ctxt_head_ptr_r (o_ctxt_head_ptr_r),
    .o_ctxt_tail_vld_r (o_ctxt_tail_vld_r),
    .o_ctxt_tail_ptr_r (o_ctxt_tail_ptr_r),
    .o_ctxt_empty_r    (o_ctxt_empty_r),
    .o_ad_busy_r       (o_ad_busy_r),
    .o_err_ovf_r       (o_err_ovf_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic uc(input logic vld, input int eng, input logic [1:0] op,
                    input logic [7:0] hp, input logic [7:0] tp,
                    input logic [7:0] pp, input logic [127:0] dat);
    bus.wrbk_uc_vld_r      = vld;
    bus.wrbk_uc_engid_r    = ENGID_W'(eng);
    bus.wrbk_uc_opcode_r   = op;
    bus.wrbk_uc_head_vld_r = (hp != 8'h00);
    bus.wrbk_uc_head_ptr_r = hp;
    bus.wrbk_uc_tail_vld_r = (tp != 8'h00);
    bus.wrbk_uc_tail_ptr_r = tp;
    bus.wrbk_pop_ptr_r     = pp;
    bus.wrbk_dat_r         = dat;
  endtask

  task automatic idle();
    uc(1'b0, 0, 2'd0, 8'h00, 8'h00, 8'h00, '0);
  endtask

  initial begin
    idle();
    bus.dealloc_rdy = 1'b0;
    arst_n = 1'b0;
    cyc(); cyc();
    arst_n = 1'b1;
    cyc();
    chk("rst_rsp_vld",  o_rsp_vld, 4'b0000);
    chk("rst_empty",    o_ctxt_empty_r, 4'b1111);
    chk("rst_hvld",     o_ctxt_head_vld_r, 4'b0000);
    chk("rst_dq_vld",   bus.dealloc_vld, 1'b0);
    chk("rst_busy",     o_ad_busy_r, 1'b0);
    chk("rst_ovf",      o_err_ovf_r, 1'b0);

    // PUSH eng2
    uc(1'b1, 2, 2'd1, 8'h05, 8'h05, 8'h00, '0);
    cyc();
    chk("push_rsp_vld", o_rsp_vld, 4'b0100);
    chk("push_err",     o_rsp_err, 1'b0);
    chk("push_dat",     o_rsp_dat, '0);
    chk("push_head2",   o_ctxt_head_ptr_r[23:16], 8'h05);
    chk("push_hvld",    o_ctxt_head_vld_r, 4'b0100);
    chk("push_empty",   o_ctxt_empty_r, 4'b1011);
    idle();
    cyc();
    chk("idle_rsp_vld", o_rsp_vld, 4'b0000);

    // POP eng2, AL ready
    bus.dealloc_rdy = 1'b1;
    uc(1'b1, 2, 2'd2, 8'h00, 8'h00, 8'h05, 128'hA5);
    cyc();
    chk("pop_rsp_vld",  o_rsp_vld, 4'b0100);
    chk("pop_err",      o_rsp_err, 1'b0);
    chk("pop_dat",      o_rsp_dat, 128'hA5);
    chk("pop_dq_vld",   bus.dealloc_vld, 1'b1);
    chk("pop_dq_ptr",   bus.dealloc_ptr, 8'h05);
    chk("pop_empty",    o_ctxt_empty_r, 4'b1111);
    idle();
    cyc();
    chk("drain1_vld",   bus.dealloc_vld, 1'b0);

    // POP on empty eng1 with bogus pointers: error, no commit
    uc(1'b1, 1, 2'd2, 8'h77, 8'h77, 8'h66, 128'hDEAD);
    cyc();
    chk("epop_rsp_vld", o_rsp_vld, 4'b0010);
    chk("epop_err",     o_rsp_err, 1'b1);
    chk("epop_dat",     o_rsp_dat, '0);
    chk("epop_dq_vld",  bus.dealloc_vld, 1'b0);
    chk("epop_hvld",    o_ctxt_head_vld_r, 4'b0000);
    chk("epop_hptr",    o_ctxt_head_ptr_r, 32'h0);
    // reserved opcode eng3
    uc(1'b1, 3, 2'd3, 8'h11, 8'h11, 8'h00, 128'h1);
    cyc();
    chk("rsvd_rsp_vld", o_rsp_vld, 4'b1000);
    chk("rsvd_err",     o_rsp_err, 1'b1);
    chk("rsvd_empty",   o_ctxt_empty_r, 4'b1111);
    // NOP eng0
    uc(1'b1, 0, 2'd0, 8'h22, 8'h22, 8'h00, 128'h1);
    cyc();
    chk("nop_rsp_vld",  o_rsp_vld, 4'b0001);
    chk("nop_err",      o_rsp_err, 1'b0);
    chk("nop_hvld",     o_ctxt_head_vld_r, 4'b0000);

    // six PUSHes to eng0
    for (int i = 0; i < 6; i++) begin
      uc(1'b1, 0, 2'd1, 8'h30 + 8'(i), 8'h40, 8'h00, '0);
      cyc();
    end
    chk("push6_head0",  o_ctxt_head_ptr_r[7:0], 8'h35);
    chk("push6_tail0",  o_ctxt_tail_ptr_r[7:0], 8'h40);
    chk("push6_empty",  o_ctxt_empty_r, 4'b1110);

    // fill the queue with AL stalled
    bus.dealloc_rdy = 1'b0;
    uc(1'b1, 0, 2'd2, 8'h35, 8'h40, 8'h20, 128'h1);
    cyc();
    chk("q1_vld",  bus.dealloc_vld, 1'b1);
    chk("q1_ptr",  bus.dealloc_ptr, 8'h20);
    chk("q1_busy", o_ad_busy_r, 1'b0);
    uc(1'b1, 0, 2'd2, 8'h35, 8'h40, 8'h21, 128'h2);
    cyc();
    chk("q2_busy", o_ad_busy_r, 1'b1);
    uc(1'b1, 0, 2'd2, 8'h35, 8'h40, 8'h22, 128'h3);
    cyc();
    chk("q3_busy", o_ad_busy_r, 1'b1);
    uc(1'b1, 0, 2'd2, 8'h35, 8'h40, 8'h23, 128'h4);
    cyc();
    chk("q4_ovf",  o_err_ovf_r, 1'b0);
    chk("q4_ptr",  bus.dealloc_ptr, 8'h20);
    // full + POP + ready in the same cycle
    bus.dealloc_rdy = 1'b1;
    uc(1'b1, 0, 2'd2, 8'h35, 8'h40, 8'h24, 128'h5);
    cyc();
    chk("fe_ovf",  o_err_ovf_r, 1'b0);
    chk("fe_ptr",  bus.dealloc_ptr, 8'h21);
    chk("fe_busy", o_ad_busy_r, 1'b1);
    chk("fe_dat",  o_rsp_dat, 128'h5);
    // full + POP without ready: dropped, sticky overflow
    bus.dealloc_rdy = 1'b0;
    uc(1'b1, 0, 2'd2, 8'h00, 8'h00, 8'h25, 128'h6);
    cyc();
    chk("ovf_set",   o_err_ovf_r, 1'b1);
    chk("ovf_rsp",   o_rsp_err, 1'b0);
    chk("ovf_ptr",   bus.dealloc_ptr, 8'h21);
    chk("ovf_empty", o_ctxt_empty_r, 4'b1111);

    // drain in FIFO order across the wrap
    idle();
    bus.dealloc_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_vld", bus.dealloc_vld, 1'b1);
      chk("drain_ptr", bus.dealloc_ptr, 8'h21 + 8'(i));
      cyc();
    end
    chk("drained_vld",  bus.dealloc_vld, 1'b0);
    chk("drained_busy", o_ad_busy_r, 1'b0);
    chk("ovf_sticky",   o_err_ovf_r, 1'b1);

    // PUSH saturation on eng3
    for (int i = 0; i < 256; i++) begin
      uc(1'b1, 3, 2'd1, 8'h01, 8'h02, 8'h00, '0);
      cyc();
    end
    chk("sat_last_err", o_rsp_err, 1'b0);
    uc(1'b1, 3, 2'd1, 8'h99, 8'h99, 8'h00, '0);
    cyc();
    chk("sat_err",   o_rsp_err, 1'b1);
    chk("sat_rsp",   o_rsp_vld, 4'b1000);
    chk("sat_head3", o_ctxt_head_ptr_r[31:24], 8'h01);

    // mid-operation reset clears everything
    idle();
    arst_n = 1'b0;
    cyc();
    arst_n = 1'b1;
    chk("rst2_ovf",   o_err_ovf_r, 1'b0);
    chk("rst2_empty", o_ctxt_empty_r, 4'b1111);
    chk("rst2_hvld",  o_ctxt_head_vld_r, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stk_pipe_wrbk.md
Name: stk_pipe_wrbk

Overview:
Writeback (WRBK) stage of the stack engine pipeline. It sits directly downstream of the MEM stage and consumes the registered wrbk_uc_* update and the popped line data. It commits per-engine stack context (head/tail/count), issues per-engine responses, and returns freed pointers to the allocator (AL) through a small dealloc queue. It throttles admission (AD) when that queue nears full.

Parameters:
ENGS_N, 4, number of engines (matches cfg_pkg::ENGS_N)
PTR_W, 8, pointer width (stk_pkg::ptr_t)
DAT_W, 128, line data width
DQ_DEPTH, 4, dealloc queue entries (power of 2, >=4)

Ports:
clk  in  1  clock
arst_n  in  1  reset; synchronous, active-low
i_wrbk_uc_vld_r  in  1  update valid from MEM
i_wrbk_uc_engid_r  in  $clog2(ENGS_N)  target engine
i_wrbk_uc_opcode_r  in  2  stk_pkg::opcode_t: NOP=0, PUSH=1, POP=2, rsvd=3
i_wrbk_uc_head_vld_r  in  1  new head valid
i_wrbk_uc_head_ptr_r  in  PTR_W  new head pointer
i_wrbk_uc_tail_vld_r  in  1  new tail valid
i_wrbk_uc_tail_ptr_r  in  PTR_W  new tail pointer
i_wrbk_pop_ptr_r  in  PTR_W  pointer of line consumed by POP
i_wrbk_dat_r  in  DAT_W  popped line data
o_rsp_vld  out  ENGS_N  one-hot response strobe
o_rsp_err  out  1  response error (POP on empty, reserved opcode)
o_rsp_dat  out  DAT_W  response data
o_ctxt_head_vld_r  out  ENGS_N  committed head valid per engine (to LK)
o_ctxt_head_ptr_r  out  ENGS_N*PTR_W  committed head per engine
o_ctxt_tail_vld_r  out  ENGS_N  committed tail valid per engine
o_ctxt_tail_ptr_r  out  ENGS_N*PTR_W  committed tail per engine
o_ctxt_empty_r  out  ENGS_N  count==0 per engine
o_dealloc_vld  out  1  queue head valid to AL
o_dealloc_ptr  out  PTR_W  freed pointer
i_dealloc_rdy  in  1  AL accepts this cycle
o_ad_busy_r  out  1  admission throttle
o_err_ovf_r  out  1  sticky dealloc-queue overflow

Behaviour:
- Reset (arst_n=0 at posedge): all context vld=0, ptr=0, count=0, empty=1; o_rsp_vld=0, o_rsp_err=0, o_rsp_dat=0; queue empty, o_dealloc_vld=0; o_ad_busy_r=0; o_err_ovf_r=0. Reset mid-operation discards in-flight update and queue contents.
- Decode per cycle when i_wrbk_uc_vld_r: err = (opcode==rsvd) | (opcode==POP & count[engid]==0). NOP: respond, no state change.
- Commit (registered, visible next cycle): when vld & ~err & opcode!=NOP, write head/tail vld/ptr of engid from inputs. PUSH: count+1, saturating at 2^PTR_W; saturation sets err. POP: count-1.
- Response latency: 1 cycle. o_rsp_vld[engid]=1 for exactly one cycle after the input. o_rsp_dat = i_wrbk_dat_r for successful POP, else 0. o_rsp_err=err. All outputs are 0 when no response is pending.
- Dealloc queue: a successful POP enqueues i_wrbk_pop_ptr_r. o_dealloc_vld = ~empty; o_dealloc_ptr = queue head (first-word fall-through). Dequeue on vld & i_dealloc_rdy.
- Queue boundary: simultaneous enq+deq when full is accepted, with count unchanged. Enq when full without deq drops the entry and sets o_err_ovf_r (sticky until reset). Read/write pointers wrap mod DQ_DEPTH.
- o_ad_busy_r registered: 1 when queue count >= DQ_DEPTH-2. This covers the maximum of 2 POPs in LK/MEM after throttle.
- Context outputs are registers only. There is no combinational path from inputs to outputs except o_dealloc_* from queue state.

Decomposition:
- stk_pkg: opcode_t, engid_t, ptr_t, constants OP_NOP/OP_PUSH/OP_POP, and DQ_DEPTH default.
- One sub-module: stk_pipe_wrbk_dq (parameterised FIFO with count, full/empty, overflow flag).

Test Plan:
- Reset then idle -> all o_rsp_vld=0, o_ctxt_empty_r=4'b1111, o_dealloc_vld=0, o_ad_busy_r=0.
- PUSH eng2 with head_ptr=8'h05 -> next cycle o_rsp_vld=4'b0100, err=0, dat=0; ctxt_head_ptr[2]=8'h05, empty[2]=0.
- POP eng2, pop_ptr=8'h05, dat=128'hA5 -> o_rsp_vld=4'b0100, dat=128'hA5; o_dealloc_vld=1, ptr=8'h05; empty[2]=1 after.
- POP eng1 when empty -> o_rsp_vld=4'b0010, o_rsp_err=1, dat=0; no dealloc, context unchanged.
- i_dealloc_rdy=0, 3 successful POPs -> o_ad_busy_r=1 after 2nd. 5th POP with queue full -> o_err_ovf_r=1. Then rdy=1 -> ptrs drain in FIFO order across wrap.
- Queue full + POP + rdy=1 same cycle -> count stays 4, no overflow, head advances correctly.
